// File: rtl/odd_sub_sqrt_pkg.sv
// Shared types and width helpers for the odd-number-subtraction square root.
package odd_sub_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  // Root width for a w-bit operand: ceil(w/2).
  function automatic int unsigned root_w(input int unsigned w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/odd_sub_sqrt_if.sv
// Operand/result handshake bundle between the odd-sum accumulator and the square-root block.
interface odd_sub_sqrt_if
  import odd_sub_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 6
);

  localparam int unsigned RW = root_w(WIDTH);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_root;
  logic [RW:0]       out_rem;
  logic              busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_root, out_rem, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_root, out_rem, busy
  );

endinterface

// File: rtl/odd_sub_sqrt.sv
// Integer square root by repeated subtraction of successive odd numbers.
// Returns floor(sqrt(n)) and n - root^2 through a valid/ready result port.
module odd_sub_sqrt
  import odd_sub_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic          clk,
  input  logic          reset,
  odd_sub_sqrt_if.slave bus
);

  localparam int unsigned RW = root_w(WIDTH);
  localparam int unsigned DW = WIDTH + 1;

  sqrt_state_t      ps, ns;
  logic [WIDTH-1:0] r_q, r_d;
  logic [DW-1:0]    d_q, d_d;
  logic [RW-1:0]    q_q, q_d;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps  <= IDLE;
      r_q <= '0;
      d_q <= DW'(1);
      q_q <= '0;
    end else begin
      ps  <= ns;
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  end

  // Next state and datapath updates; the compare zero-extends R to the width of D.
  always_comb begin
    ns  = ps;
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    unique case (ps)
      IDLE: begin
        if (bus.in_valid) begin
          r_d = bus.in_data;
          d_d = DW'(1);
          q_d = '0;
          ns  = CALC;
        end
      end
      CALC: begin
        if ({1'b0, r_q} >= d_q) begin
          // d_q <= r_q here, so its top bit is zero and the low bits carry the whole value.
          r_d = r_q - d_q[WIDTH-1:0];
          d_d = d_q + DW'(2);
          q_d = q_q + RW'(1);
        end else begin
          ns = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ns = IDLE;
        end
      end
      default: ns = IDLE;
    endcase
  end

  // Handshake and result outputs decode straight from registers.
  assign bus.in_ready  = (ps == IDLE);
  assign bus.out_valid = (ps == DONE);
  assign bus.busy      = (ps == CALC) || (ps == DONE);
  assign bus.out_root  = q_q;
  assign bus.out_rem   = r_q[RW:0];

endmodule

// File: tb/tb_odd_sub_sqrt.sv
// Scoreboard bench for odd_sub_sqrt: expected results queued at accept, checked at output.
module tb_odd_sub_sqrt;
  import odd_sub_sqrt_pkg::*;

  localparam int unsigned WIDTH = 6;

  typedef struct {
    int n;
    int root;
    int rem;
  } res_t;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  odd_sub_sqrt_if #(.WIDTH(WIDTH)) bus ();

  odd_sub_sqrt #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic push_exp(input int n);
    res_t e;
    e.n    = n;
    e.root = isqrt(n);
    e.rem  = n - e.root * e.root;
    exp_q.push_back(e);
  endtask

  // Present an operand and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input int n, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(n);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push_exp(n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns at the negedge where it is first seen, with edges since accept.
  task automatic wait_result(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_root !== 3'd0 || bus.out_rem !== 4'd0) begin
      miscompares++;
      $display("FAIL reset: valid=%b ready=%b busy=%b root=%0d rem=%0d, expected 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_root, bus.out_rem);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok_s, ok_r;
    int edges;
    res_t e;
    send(25, ok_s);
    wait_result(edges, ok_r);
    vectors++;
    if (!ok_s || !ok_r || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL basic_timeout: accepted=%0d result=%0d, expected 1 1", ok_s, ok_r);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (edges + 1 !== 7) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges, expected 7", edges + 1);
    end
    vectors++;
    if (int'(bus.out_root) !== 5 || int'(bus.out_rem) !== 0 ||
        int'(bus.out_root) !== e.root || int'(bus.out_rem) !== e.rem) begin
      miscompares++;
      $display("FAIL basic_result: got %0d/%0d, expected 5/0", bus.out_root, bus.out_rem);
    end
    consume();
  endtask

  task automatic test_sweep();
    bit ok_s, ok_r;
    int edges, root, rem;
    res_t e;
    for (int n = 0; n < 64; n++) begin
      send(n, ok_s);
      wait_result(edges, ok_r);
      vectors++;
      if (!ok_s || !ok_r || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sweep_timeout n=%0d: accepted=%0d result=%0d", n, ok_s, ok_r);
        exp_q.delete();
        continue;
      end
      e    = exp_q.pop_front();
      root = int'(bus.out_root);
      rem  = int'(bus.out_rem);
      vectors++;
      if (root !== e.root || rem !== e.rem) begin
        miscompares++;
        $display("FAIL sweep_result n=%0d: got %0d/%0d, expected %0d/%0d", n, root, rem, e.root, e.rem);
      end
      vectors++;
      if (root * root + rem !== n || rem > 2 * root) begin
        miscompares++;
        $display("FAIL sweep_identity n=%0d: root=%0d rem=%0d violates root^2+rem==n, rem<=2*root", n, root, rem);
      end
      vectors++;
      if (edges + 1 !== e.root + 2) begin
        miscompares++;
        $display("FAIL sweep_latency n=%0d: got %0d, expected %0d", n, edges + 1, e.root + 2);
      end
      if (n == 0 || n == 48 || n == 63) begin
        vectors++;
        if ((n == 0  && (root !== 0 || rem !== 0)) ||
            (n == 48 && (root !== 6 || rem !== 12)) ||
            (n == 63 && (root !== 7 || rem !== 14))) begin
          miscompares++;
          $display("FAIL sweep_corner n=%0d: got %0d/%0d", n, root, rem);
        end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    bit ok_s, ok_r;
    int edges;
    res_t e;
    bus.out_ready = 1'b0;
    send(10, ok_s);
    wait_result(edges, ok_r);
    vectors++;
    if (!ok_s || !ok_r || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL bp_timeout: accepted=%0d result=%0d, expected 1 1", ok_s, ok_r);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
          int'(bus.out_root) !== e.root || int'(bus.out_rem) !== e.rem ||
          int'(bus.out_root) !== 3 || int'(bus.out_rem) !== 1) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d: valid=%b ready=%b busy=%b root=%0d rem=%0d, expected 1 0 1 3 1",
                 c, bus.out_valid, bus.in_ready, bus.busy, bus.out_root, bus.out_rem);
      end
      @(posedge clk);
      @(negedge clk);
    end
    consume();
  endtask

  task automatic test_held_valid();
    int   accepts = 0;
    int   results = 0;
    bit   swap, drop;
    res_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(20);
    for (int c = 0; c < 100 && results < 2; c++) begin
      @(negedge clk);
      swap = 1'b0;
      drop = 1'b0;
      if (bus.busy && bus.in_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL held_ready: got in_ready=1 while busy, expected 0");
      end
      if (bus.in_valid && bus.in_ready) begin
        accepts++;
        push_exp(int'(bus.in_data));
        if (int'(bus.in_data) == 20) swap = 1'b1;
        else drop = 1'b1;
      end
      if (bus.out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL held_unexpected: got %0d/%0d with nothing pending", bus.out_root, bus.out_rem);
        end else begin
          e = exp_q.pop_front();
          if (int'(bus.out_root) !== e.root || int'(bus.out_rem) !== e.rem) begin
            miscompares++;
            $display("FAIL held_result n=%0d: got %0d/%0d, expected %0d/%0d",
                     e.n, bus.out_root, bus.out_rem, e.root, e.rem);
          end
        end
        results++;
        if (results == 2) begin
          vectors++;
          if (int'(bus.out_root) !== 3 || int'(bus.out_rem) !== 0) begin
            miscompares++;
            $display("FAIL held_second: got %0d/%0d, expected 3/0", bus.out_root, bus.out_rem);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (swap) bus.in_data  = WIDTH'(9);
      if (drop) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (results !== 2) begin
      miscompares++;
      $display("FAIL held_timeout: got %0d results, expected 2", results);
    end
    vectors++;
    if (accepts !== 2) begin
      miscompares++;
      $display("FAIL held_accepts: got %0d, expected 2", accepts);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok_s, ok_r;
    int edges;
    res_t e;
    send(63, ok_s);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_root !== 3'd0 || bus.out_rem !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset: valid=%b ready=%b busy=%b root=%0d rem=%0d, expected 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_root, bus.out_rem);
    end
    reset = 1'b0;
    send(16, ok_s);
    wait_result(edges, ok_r);
    vectors++;
    if (!ok_s || !ok_r || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL midreset_timeout: accepted=%0d result=%0d, expected 1 1", ok_s, ok_r);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (int'(bus.out_root) !== 4 || int'(bus.out_rem) !== 0 ||
        int'(bus.out_root) !== e.root || int'(bus.out_rem) !== e.rem) begin
      miscompares++;
      $display("FAIL midreset_result: got %0d/%0d, expected 4/0", bus.out_root, bus.out_rem);
    end
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_held_valid();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
